// File: rtl/aes_pkg.sv
// Shared AES widths, the core pipeline depth, and the loader FSM state encoding.
package aes_pkg;
  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_PIPE_LAT      = 10;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_FILL = 1'b1
  } ld_state_e;
endpackage

// File: rtl/aes_valid_delay.sv
// DEPTH-stage shift register of {valid, seq}. Latency is DEPTH edges and there is no backpressure.
// The async clear flushes in-flight tags so that no stale valid appears after reset.
module aes_valid_delay #(
  parameter int DEPTH = 10,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [SEQ_W-1:0] seq,
  output logic             dly_valid,
  output logic [SEQ_W-1:0] dly_seq
);
  logic [DEPTH-1:0] vld_sr;
  logic [SEQ_W-1:0] seq_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) seq_sr[i] <= '0;
    end else begin
      vld_sr[0] <= valid;
      seq_sr[0] <= seq;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        seq_sr[i] <= seq_sr[i-1];
      end
    end
  end

  assign dly_valid = vld_sr[DEPTH-1];
  assign dly_seq   = seq_sr[DEPTH-1];
endmodule

// File: rtl/aes_block_loader.sv
// Packs 32-bit words into AES key/plaintext blocks and tags each issued block through the core latency.
// ct_valid follows blk_issued by PIPE_LAT edges; hold deasserts in_ready and freezes packing.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int PIPE_LAT = AES_PIPE_LAT,
  parameter int SEQ_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] in_data,
  input  logic                  in_is_key,
  input  logic                  hold,
  input  logic                  err_clr,
  output logic [AES_BLK_W-1:0]  core_data,
  output logic [AES_BLK_W-1:0]  core_key,
  output logic                  key_valid,
  output logic                  blk_issued,
  output logic                  ct_valid,
  output logic [SEQ_W-1:0]      ct_seq,
  output logic                  err_proto,
  output logic                  err_nokey
);
  localparam int ACC_W = AES_BLK_W - AES_WORD_W;

  ld_state_e             state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  run_q;
  logic [ACC_W-1:0]      acc_q;
  logic                  blk_is_key_q;
  logic [SEQ_W-1:0]      seq_cnt_q, iss_seq_q;
  logic                  accept, proto_err, blk_done;
  logic                  issue_now, key_load, nokey_blk;
  logic [AES_BLK_W-1:0]  blk;

  assign in_ready  = run_q & ~hold;
  assign accept    = in_valid & in_ready;
  assign proto_err = accept & (state_q == LD_FILL) & (in_is_key != blk_is_key_q);
  assign blk_done  = accept & (cnt_q == 2'(AES_WORDS_PER_BLK - 1)) & ~proto_err;
  assign blk       = {acc_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mismatching word restarts packing as word 0 of a fresh block.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (proto_err) begin
        state_d = LD_FILL;
        cnt_d   = 2'd1;
      end else if (cnt_q == 2'(AES_WORDS_PER_BLK - 1)) begin
        state_d = LD_IDLE;
        cnt_d   = 2'd0;
      end else begin
        state_d = LD_FILL;
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    issue_now = 1'b0;
    key_load  = 1'b0;
    nokey_blk = 1'b0;
    if (blk_done) begin
      key_load  = blk_is_key_q;
      issue_now = ~blk_is_key_q & key_valid;
      nokey_blk = ~blk_is_key_q & ~key_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      acc_q        <= '0;
      blk_is_key_q <= 1'b0;
      core_data    <= '0;
      core_key     <= '0;
      key_valid    <= 1'b0;
      blk_issued   <= 1'b0;
      seq_cnt_q    <= '0;
      iss_seq_q    <= '0;
      err_proto    <= 1'b0;
      err_nokey    <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      blk_issued <= issue_now;
      if (accept) acc_q <= {acc_q[ACC_W-AES_WORD_W-1:0], in_data};
      if (accept && (state_q == LD_IDLE || proto_err)) blk_is_key_q <= in_is_key;
      if (key_load) begin
        core_key  <= blk;
        key_valid <= 1'b1;
      end
      if (issue_now) begin
        core_data <= blk;
        iss_seq_q <= seq_cnt_q;
        seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
      end
      // Set takes priority over a simultaneous clear.
      if (proto_err)    err_proto <= 1'b1;
      else if (err_clr) err_proto <= 1'b0;
      if (nokey_blk)    err_nokey <= 1'b1;
      else if (err_clr) err_nokey <= 1'b0;
    end
  end

  // Feeding the registered issue pulse gives exactly PIPE_LAT edges from the core_data load.
  aes_valid_delay #(.DEPTH(PIPE_LAT), .SEQ_W(SEQ_W)) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (blk_issued),
    .seq       (blk_issued ? iss_seq_q : '0),
    .dly_valid (ct_valid),
    .dly_seq   (ct_seq)
  );
endmodule
